share_buffer: RTL and testbench

SHARE_BUFFER -- requirements
Module: share_buffer

---
 rtl/share_buffer.sv | 128 ++++++++++++
 tb/tb_share_buffer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/share_buffer.sv
// ---------------------------------------------------------------------------
// share_buffer
//
// Collects winning nonces ("shares") from the hash compare stage and queues
// them for the host. Each accepted hit gets a sequence number. The number
// advances for every hit, including hits lost to a full buffer, so the host
// can spot lost shares as gaps in the sequence.
//
// Ports
//   clk          : single clock, rising edge
//   rst_n        : asynchronous active-low reset
//   flush        : new work loaded; discard all queued shares
//   hit_valid    : single-cycle pulse, hit_nonce met the target
//   hit_nonce    : winning nonce (32 bits)
//   out_valid    : a share is presented to the host
//   out_ready    : host consumes the presented share this cycle
//   out_nonce    : nonce of the oldest share (0 when empty)
//   out_seq      : sequence number of the oldest share (0 when empty)
//   level        : number of queued shares, 0..DEPTH
//   dropped      : saturating count of hits lost to a full buffer
//   overflow     : sticky flag, set on any dropped hit
//   clr_overflow : clears dropped and overflow
// ---------------------------------------------------------------------------
module share_buffer #(
   parameter int DEPTH = 8,
   parameter int SEQ_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     hit_valid,
   input  logic [31:0]              hit_nonce,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_nonce,
   output logic [SEQ_W-1:0]         out_seq,
   output logic [$clog2(DEPTH):0]   level,
   output logic [SEQ_W-1:0]         dropped,
   output logic                     overflow,
   input  logic                     clr_overflow
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

   // Saturating increment for the drop counter.
   function automatic logic [SEQ_W-1:0] sat_inc(input logic [SEQ_W-1:0] v);
      return (&v) ? v : v + SEQ_W'(1);
   endfunction

   logic [31:0]      nonce_mem [DEPTH];
   logic [SEQ_W-1:0] seq_mem   [DEPTH];

   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      cnt;
   logic [SEQ_W-1:0] next_seq;

   logic             pop;
   logic             push;
   logic             drop;
   logic             hit_live;

   // flush suppresses everything else happening in the same cycle. A full
   // buffer can still accept a hit when the host pops in that same cycle.
   always_comb begin
      hit_live = hit_valid && !flush;
      pop      = (cnt != '0) && out_ready && !flush;
      push     = hit_live && ((cnt != FULL_LVL) || pop);
      drop     = hit_live && !push;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         cnt      <= '0;
         next_seq <= '0;
      end else begin
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
               2'b10:   cnt <= cnt + (AW+1)'(1);
               2'b01:   cnt <= cnt - (AW+1)'(1);
               default: cnt <= cnt;
            endcase
         end
         // Dropped hits consume a number too, so the host sees the gap.
         if (hit_live) next_seq <= next_seq + SEQ_W'(1);
      end
   end

   // A drop in the same cycle as a clear wins: the counter restarts at 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dropped  <= '0;
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
         dropped  <= clr_overflow ? SEQ_W'(1) : sat_inc(dropped);
      end else if (clr_overflow) begin
         overflow <= 1'b0;
         dropped  <= '0;
      end
   end

   // Storage is not reset; the read side is gated by the occupancy instead.
   always_ff @(posedge clk) begin
      if (push) begin
         nonce_mem[wr_ptr] <= hit_nonce;
         seq_mem[wr_ptr]   <= next_seq;
      end
   end

   // First-word-fall-through read of the oldest entry.
   always_comb begin
      out_valid = (cnt != '0);
      out_nonce = out_valid ? nonce_mem[rd_ptr] : '0;
      out_seq   = out_valid ? seq_mem[rd_ptr]   : '0;
      level     = cnt;
   end

endmodule

// File: tb/tb_share_buffer.sv
module tb_share_buffer;

   localparam int DEPTH = 8;
   localparam int SEQ_W = 16;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        hit_valid;
   logic [31:0] hit_nonce;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_nonce;
   logic [15:0] out_seq;
   logic [3:0]  level;
   logic [15:0] dropped;
   logic        overflow;
   logic        clr_overflow;

   share_buffer #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .hit_valid    (hit_valid),
      .hit_nonce    (hit_nonce),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_nonce    (out_nonce),
      .out_seq      (out_seq),
      .level        (level),
      .dropped      (dropped),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   typedef struct {
      logic [15:0] seq;
      logic [31:0] nonce;
   } ent_t;

   ent_t mq[$];
   int   m_next;
   int   m_drop;
   bit   m_ovf;

   task automatic model_reset();
      mq.delete();
      m_next = 0;
      m_drop = 0;
      m_ovf  = 0;
   endtask

   task automatic model_step(input bit f, input bit h, input logic [31:0] n,
                             input bit r, input bit c);
      ent_t e;
      if (c) begin
         m_drop = 0;
         m_ovf  = 0;
      end
      if (f) begin
         mq.delete();
      end else begin
         if (r && mq.size() > 0) void'(mq.pop_front());
         if (h) begin
            if (mq.size() < DEPTH) begin
               e.seq   = 16'(m_next);
               e.nonce = n;
               mq.push_back(e);
            end else begin
               m_ovf = 1;
               if (m_drop < 65535) m_drop++;
            end
            m_next = (m_next + 1) % 65536;
         end
      end
   endtask

   task automatic model_check();
      bit          ev;
      logic [31:0] en;
      logic [15:0] es;
      ev = (mq.size() != 0);
      en = ev ? mq[0].nonce : 32'h0;
      es = ev ? mq[0].seq   : 16'h0;
      check("model out_valid", 64'(out_valid), 64'(ev));
      check("model out_nonce", 64'(out_nonce), 64'(en));
      check("model out_seq",   64'(out_seq),   64'(es));
      check("model level",     64'(level),     64'(mq.size()));
      check("model dropped",   64'(dropped),   64'(m_drop));
      check("model overflow",  64'(overflow),  64'(m_ovf));
   endtask

   // Drive one cycle's inputs, clock it, and compare against the model.
   // Called at posedge+1, returns at posedge+1.
   task automatic cycle(input bit f, input bit h, input logic [31:0] n,
                        input bit r, input bit c);
      flush        = f;
      hit_valid    = h;
      hit_nonce    = n;
      out_ready    = r;
      clr_overflow = c;
      model_step(f, h, n, r, c);
      @(posedge clk);
      #1;
      model_check();
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic do_reset();
      flush = 0; hit_valid = 0; hit_nonce = 0; out_ready = 0; clr_overflow = 0;
      #2 rst_n = 1'b0;
      #1;
      check("async rst out_valid", 64'(out_valid), 64'(0));
      check("async rst out_nonce", 64'(out_nonce), 64'(0));
      check("async rst out_seq",   64'(out_seq),   64'(0));
      check("async rst level",     64'(level),     64'(0));
      check("async rst dropped",   64'(dropped),   64'(0));
      check("async rst overflow",  64'(overflow),  64'(0));
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   typedef struct {
      bit          flush;
      bit          hit;
      logic [31:0] nonce;
      bit          ready;
      bit          clr;
      bit          e_valid;
      logic [31:0] e_nonce;
      logic [15:0] e_seq;
      logic [3:0]  e_level;
      logic [15:0] e_drop;
      bit          e_ovf;
   } vec_t;

   vec_t vt[11];

   initial begin
      vt[0]  = '{0, 1, 32'h1234ABCD, 0, 0, 1, 32'h1234ABCD, 16'd0, 4'd1, 16'd0, 0};
      vt[1]  = '{0, 1, 32'h00000011, 0, 0, 1, 32'h1234ABCD, 16'd0, 4'd2, 16'd0, 0};
      vt[2]  = '{0, 1, 32'h00000022, 1, 0, 1, 32'h00000011, 16'd1, 4'd2, 16'd0, 0};
      vt[3]  = '{0, 0, 32'h00000000, 1, 0, 1, 32'h00000022, 16'd2, 4'd1, 16'd0, 0};
      vt[4]  = '{0, 1, 32'h00000033, 0, 0, 1, 32'h00000022, 16'd2, 4'd2, 16'd0, 0};
      vt[5]  = '{0, 1, 32'h00000044, 0, 0, 1, 32'h00000022, 16'd2, 4'd3, 16'd0, 0};
      vt[6]  = '{1, 1, 32'h00000055, 1, 0, 0, 32'h00000000, 16'd0, 4'd0, 16'd0, 0};
      vt[7]  = '{0, 1, 32'h00000066, 1, 0, 1, 32'h00000066, 16'd5, 4'd1, 16'd0, 0};
      vt[8]  = '{0, 0, 32'h00000000, 0, 1, 1, 32'h00000066, 16'd5, 4'd1, 16'd0, 0};
      vt[9]  = '{0, 0, 32'h00000000, 1, 0, 0, 32'h00000000, 16'd0, 4'd0, 16'd0, 0};
      vt[10] = '{0, 0, 32'h00000000, 1, 0, 0, 32'h00000000, 16'd0, 4'd0, 16'd0, 0};

      rst_n = 1'b0;
      flush = 0; hit_valid = 0; hit_nonce = 0; out_ready = 0; clr_overflow = 0;
      model_reset();
      @(posedge clk);
      #1;
      check("reset out_valid", 64'(out_valid), 64'(0));
      check("reset level",     64'(level),     64'(0));
      check("reset out_nonce", 64'(out_nonce), 64'(0));
      check("reset out_seq",   64'(out_seq),   64'(0));
      check("reset dropped",   64'(dropped),   64'(0));
      check("reset overflow",  64'(overflow),  64'(0));
      rst_n = 1'b1;

      // ---------------- table-driven vectors ----------------
      for (int i = 0; i < 11; i++) begin
         cycle(vt[i].flush, vt[i].hit, vt[i].nonce, vt[i].ready, vt[i].clr);
         check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vt[i].e_valid));
         check($sformatf("vec%0d out_nonce", i), 64'(out_nonce), 64'(vt[i].e_nonce));
         check($sformatf("vec%0d out_seq", i),   64'(out_seq),   64'(vt[i].e_seq));
         check($sformatf("vec%0d level", i),     64'(level),     64'(vt[i].e_level));
         check($sformatf("vec%0d dropped", i),   64'(dropped),   64'(vt[i].e_drop));
         check($sformatf("vec%0d overflow", i),  64'(overflow),  64'(vt[i].e_ovf));
      end

      // ---------------- async reset with level=5 ----------------
      for (int i = 0; i < 5; i++) cycle(0, 1, 32'hA000 + i, 0, 0);
      check("pre-reset level", 64'(level), 64'(5));
      do_reset();

      // ---------------- fill past full, then drain ----------------
      for (int i = 1; i <= 10; i++) cycle(0, 1, 32'(i), 0, 0);
      check("fill level",    64'(level),    64'(8));
      check("fill dropped",  64'(dropped),  64'(2));
      check("fill overflow", 64'(overflow), 64'(1));
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("drain%0d valid", i), 64'(out_valid), 64'(1));
         check($sformatf("drain%0d nonce", i), 64'(out_nonce), 64'(i));
         check($sformatf("drain%0d seq", i),   64'(out_seq),   64'(i - 1));
         cycle(0, 0, 0, 1, 0);
      end
      check("drained valid", 64'(out_valid), 64'(0));
      check("drained nonce", 64'(out_nonce), 64'(0));

      // Refill (seq 10..17), then a drop coinciding with a clear.
      for (int i = 0; i < 8; i++) cycle(0, 1, 32'h100 + i, 0, 0);
      cycle(0, 1, 32'hDEAD, 0, 1);
      check("clr+drop overflow", 64'(overflow), 64'(1));
      check("clr+drop dropped",  64'(dropped),  64'(1));

      // Full buffer, push and pop together: entry goes in at the tail.
      cycle(0, 1, 32'hBEEF, 1, 0);
      check("full push+pop level",   64'(level),   64'(8));
      check("full push+pop dropped", 64'(dropped), 64'(1));
      for (int i = 0; i < 7; i++) cycle(0, 0, 0, 1, 0);
      check("tail entry nonce", 64'(out_nonce), 64'(32'hBEEF));
      check("tail entry seq",   64'(out_seq),   64'(19));

      // Flush with a hit and a pop in the same cycle.
      cycle(1, 1, 32'hCAFE, 1, 0);
      check("flush level",    64'(level),     64'(0));
      check("flush valid",    64'(out_valid), 64'(0));
      check("flush dropped",  64'(dropped),   64'(1));
      check("flush overflow", 64'(overflow),  64'(1));
      cycle(0, 1, 32'hF00, 0, 0);
      check("post-flush seq", 64'(out_seq), 64'(20));
      cycle(0, 0, 0, 1, 1);
      check("clr dropped",  64'(dropped),  64'(0));
      check("clr overflow", 64'(overflow), 64'(0));

      // ---------------- sequence wrap and drop saturation ----------------
      do_reset();
      for (int i = 0; i < 8; i++) cycle(0, 1, 32'h200 + i, 0, 0);
      for (int i = 0; i < 65527; i++) cycle(0, 1, 32'h300, 0, 0);
      cycle(0, 1, 32'hF00D, 1, 0);
      cycle(0, 1, 32'hF00E, 1, 0);
      for (int i = 0; i < 20; i++) cycle(0, 1, 32'h400, 0, 0);
      check("sat dropped",  64'(dropped),  64'(16'hFFFF));
      check("sat overflow", 64'(overflow), 64'(1));
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 0);
      check("wrap seq FFFF nonce", 64'(out_nonce), 64'(32'hF00D));
      check("wrap seq FFFF",       64'(out_seq),    64'(16'hFFFF));
      cycle(0, 0, 0, 1, 0);
      check("wrap seq 0 nonce", 64'(out_nonce), 64'(32'hF00E));
      check("wrap seq 0",       64'(out_seq),    64'(0));
      cycle(0, 0, 0, 1, 1);

      // ---------------- randomized traffic against the model ----------------
      do_reset();
      for (int blk = 0; blk < 5; blk++) begin
         int rthr;
         rthr = (blk % 3 == 0) ? 1 : ((blk % 3 == 1) ? 2 : 3);
         for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 1) == 1),
                  $urandom,
                  ($urandom_range(0, 3) < rthr),
                  ($urandom_range(0, 31) == 0));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
